// File: rtl/exu_hazard_sequencer_if.sv
// ---------------------------------------------------------------------------
// exu_hazard_sequencer_if
//
// Bundles the pipeline-side signals of the execute-stage hazard sequencer.
//
//   master : pipeline / bench side. Drives the decode/execute/memory/writeback
//            hazard information and the multi-cycle handshake. Receives the
//            forwarding selects, stall/flush controls and status.
//   slave  : exu_hazard_sequencer side (the reverse directions).
//
// REG_ADDR_W and PERF_W must match the parameters of the sequencer that
// uses this interface.
// ---------------------------------------------------------------------------
interface exu_hazard_sequencer_if #(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_W     = 32
);

  // Multi-cycle handshake
  logic                  Dvalid;
  logic                  Mready;
  logic                  Evalid;
  logic                  MultiCycleE;

  // Register indices and write enables along the pipe
  logic [REG_ADDR_W-1:0] Rs1D;
  logic [REG_ADDR_W-1:0] Rs2D;
  logic [REG_ADDR_W-1:0] Rs1E;
  logic [REG_ADDR_W-1:0] Rs2E;
  logic [REG_ADDR_W-1:0] RdE;
  logic                  MemReadE;
  logic [REG_ADDR_W-1:0] RdM;
  logic [REG_ADDR_W-1:0] RdW;
  logic                  RegWriteM;
  logic                  RegWriteW;
  logic [1:0]            PCSrcE;

  // Controls and status returned to the pipeline
  logic [1:0]            ForwardAE;
  logic [1:0]            ForwardBE;
  logic                  StallF;
  logic                  StallD;
  logic                  FlushD;
  logic                  FlushE;
  logic                  ExStart;
  logic                  ExBusy;
  logic                  err_timeout;
  logic [PERF_W-1:0]     stall_cnt;

  modport master (
    output Dvalid, Mready, Evalid, MultiCycleE,
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, MemReadE,
    output RdM, RdW, RegWriteM, RegWriteW, PCSrcE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    input  ExStart, ExBusy, err_timeout, stall_cnt
  );

  modport slave (
    input  Dvalid, Mready, Evalid, MultiCycleE,
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, MemReadE,
    input  RdM, RdW, RegWriteM, RegWriteW, PCSrcE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    output ExStart, ExBusy, err_timeout, stall_cnt
  );

endinterface

// File: rtl/exu_hazard_sequencer.sv
// ---------------------------------------------------------------------------
// exu_hazard_sequencer
//
// Pipeline control for the execute stage:
//   - operand forwarding selects (M has priority over W, x0 never forwarded)
//   - load-use stall detection
//   - branch/jump/trap flush of IF/ID and ID/EX
//   - IDLE/BUSY/HOLD sequencing of multi-cycle ALU ops (mul/div)
//   - stall-cycle performance counter and sticky busy-timeout flag
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset; every output reads 0 while high
//   bus  : exu_hazard_sequencer_if.slave
//            in : Dvalid, Mready, Evalid, MultiCycleE, Rs1D, Rs2D, Rs1E,
//                 Rs2E, RdE, MemReadE, RdM, RdW, RegWriteM, RegWriteW, PCSrcE
//            out: ForwardAE, ForwardBE (00=RD, 01=ResultW, 10=ALUResultM),
//                 StallF, StallD, FlushD, FlushE, ExStart, ExBusy,
//                 err_timeout, stall_cnt
// ---------------------------------------------------------------------------
module exu_hazard_sequencer #(
  parameter int REG_ADDR_W   = 5,
  parameter int PERF_W       = 32,
  parameter int BUSY_TIMEOUT = 64
) (
  input logic                    clk,
  input logic                    rst,
  exu_hazard_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_e;

  // The busy counter must be able to hold BUSY_TIMEOUT itself (saturation value)
  localparam int                    CNT_W   = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(BUSY_TIMEOUT);
  localparam logic [REG_ADDR_W-1:0] REG_X0  = '0;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   busy_cnt_q, busy_cnt_d;
  logic               err_q, err_d;
  logic [PERF_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [1:0]         fwd_a, fwd_b;
  logic               load_use;
  logic               redirect;
  logic               ex_busy;
  logic               ex_start;
  logic               stall;
  logic               flush_d;
  logic               flush_e;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic                  we_m,
    input logic [REG_ADDR_W-1:0] rd_w,
    input logic                  we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m != REG_X0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != REG_X0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Hazard detection. ExStart is a Mealy pulse taken in the IDLE cycle that
  // launches the op, so the launching instruction is already stalled.
  always_comb begin
    fwd_a    = fwd_sel(bus.Rs1E, bus.RdM, bus.RegWriteM, bus.RdW, bus.RegWriteW);
    fwd_b    = fwd_sel(bus.Rs2E, bus.RdM, bus.RegWriteM, bus.RdW, bus.RegWriteW);
    load_use = bus.MemReadE && (bus.RdE != REG_X0) &&
               ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
    redirect = (bus.PCSrcE != 2'b00);
    ex_busy  = (state_q != IDLE);
    ex_start = (state_q == IDLE) && bus.Dvalid && bus.MultiCycleE;
    stall    = load_use || ex_busy || ex_start;
    // A redirect from E is ignored while a multi-cycle op owns the stage
    flush_d  = redirect && !ex_busy;
    flush_e  = load_use || flush_d;
  end

  // Next-state logic for the sequencer, busy counter, timeout flag and
  // stall counter. Evalid is only looked at in BUSY, so a completion that
  // coincides with the launch cycle is dropped.
  always_comb begin
    state_d     = state_q;
    busy_cnt_d  = busy_cnt_q;
    err_d       = err_q;
    stall_cnt_d = stall ? (stall_cnt_q + PERF_W'(1)) : stall_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (ex_start) begin
          state_d    = BUSY;
          busy_cnt_d = '0;
        end
      end
      BUSY: begin
        if (busy_cnt_q != CNT_MAX) begin
          busy_cnt_d = busy_cnt_q + CNT_W'(1);
        end
        if (bus.Evalid) begin
          state_d = bus.Mready ? IDLE : HOLD;
        end else if (busy_cnt_d == CNT_MAX) begin
          err_d = 1'b1;
        end
      end
      HOLD: begin
        if (bus.Mready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_cnt_q  <= busy_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Combinational outputs are forced low during reset so nothing downstream
  // sees a stall, flush or forward while the block is held in reset.
  assign bus.ForwardAE   = rst ? 2'b00 : fwd_a;
  assign bus.ForwardBE   = rst ? 2'b00 : fwd_b;
  assign bus.StallF      = !rst && stall;
  assign bus.StallD      = !rst && stall;
  assign bus.FlushD      = !rst && flush_d;
  assign bus.FlushE      = !rst && flush_e;
  assign bus.ExStart     = !rst && ex_start;
  assign bus.ExBusy      = !rst && ex_busy;
  assign bus.err_timeout = err_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_exu_hazard_sequencer.sv
// ---------------------------------------------------------------------------
// tb_exu_hazard_sequencer
//
// Self-checking bench for exu_hazard_sequencer. A behavioural model tracks
// whether a multi-cycle op is running or waiting on memory, how long it has
// run, the timeout flag and the number of stalled cycles; a compare process
// checks every DUT output against it on each falling edge. Directed vectors
// with hand-computed values pin the model.
// ---------------------------------------------------------------------------
module tb_exu_hazard_sequencer;

  localparam int REG_ADDR_W   = 5;
  localparam int PERF_W       = 32;
  localparam int BUSY_TIMEOUT = 64;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  exu_hazard_sequencer_if #(.REG_ADDR_W(REG_ADDR_W), .PERF_W(PERF_W)) bus ();

  exu_hazard_sequencer #(
    .REG_ADDR_W  (REG_ADDR_W),
    .PERF_W      (PERF_W),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------------
  // Behavioural model
  // ------------------------------------------------------------------
  bit          mdl_running;
  bit          mdl_wait_mem;
  int          mdl_busy_cycles;
  bit          mdl_err;
  logic [31:0] mdl_stalls;

  function automatic logic [1:0] exp_fwd(input int rs, input int rd_m, input bit we_m,
                                         input int rd_w, input bit we_w);
    if (we_m && rd_m != 0 && rd_m == rs) return 2'd2;
    if (we_w && rd_w != 0 && rd_w == rs) return 2'd1;
    return 2'd0;
  endfunction

  logic [1:0] e_fa, e_fb;
  bit e_busy, e_start, e_lu, e_redir, e_stall, e_fd, e_fe;

  always @(negedge clk) begin
    if (rst) begin
      mdl_running     = 0;
      mdl_wait_mem    = 0;
      mdl_busy_cycles = 0;
      mdl_err         = 0;
      mdl_stalls      = 0;
      e_fa = 0; e_fb = 0; e_busy = 0; e_start = 0; e_stall = 0; e_fd = 0; e_fe = 0;
    end else begin
      e_fa    = exp_fwd(int'(bus.Rs1E), int'(bus.RdM), bus.RegWriteM, int'(bus.RdW), bus.RegWriteW);
      e_fb    = exp_fwd(int'(bus.Rs2E), int'(bus.RdM), bus.RegWriteM, int'(bus.RdW), bus.RegWriteW);
      e_busy  = mdl_running || mdl_wait_mem;
      e_start = !e_busy && bus.Dvalid && bus.MultiCycleE;
      e_lu    = bus.MemReadE && bus.RdE != 0 && (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
      e_redir = bus.PCSrcE != 0;
      e_stall = e_lu || e_busy || e_start;
      e_fd    = e_redir && !e_busy;
      e_fe    = e_lu || e_fd;
    end

    check_output("ForwardAE", bus.ForwardAE, e_fa);
    check_output("ForwardBE", bus.ForwardBE, e_fb);
    check_output("StallF", bus.StallF, e_stall);
    check_output("StallD", bus.StallD, e_stall);
    check_output("FlushD", bus.FlushD, e_fd);
    check_output("FlushE", bus.FlushE, e_fe);
    check_output("ExStart", bus.ExStart, e_start);
    check_output("ExBusy", bus.ExBusy, e_busy);
    check_output("err_timeout", bus.err_timeout, mdl_err);
    check_output("stall_cnt", bus.stall_cnt, mdl_stalls);

    // Advance the model to what the coming rising edge will produce
    if (!rst) begin
      if (e_stall) mdl_stalls = mdl_stalls + 1;
      if (e_start) begin
        mdl_running     = 1;
        mdl_busy_cycles = 0;
      end else if (mdl_running) begin
        if (bus.Evalid) begin
          mdl_running  = 0;
          mdl_wait_mem = !bus.Mready;
        end else begin
          mdl_busy_cycles++;
          if (mdl_busy_cycles >= BUSY_TIMEOUT) mdl_err = 1;
        end
      end else if (mdl_wait_mem && bus.Mready) begin
        mdl_wait_mem = 0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Directed forwarding vectors with hand-computed selects
  // ------------------------------------------------------------------
  typedef struct {
    int rs1e; int rs2e; int rdm; int rdw; bit wem; bit wew;
    logic [1:0] exp_a; logic [1:0] exp_b;
  } fwd_vec_t;

  fwd_vec_t fwd_vecs[5] = '{
    '{1, 2, 1, 2, 1, 1, 2'd2, 2'd1},
    '{3, 3, 3, 3, 0, 1, 2'd1, 2'd1},
    '{4, 0, 4, 0, 1, 1, 2'd2, 2'd0},
    '{6, 7, 0, 7, 1, 1, 2'd0, 2'd1},
    '{9, 9, 8, 9, 1, 0, 2'd0, 2'd0}
  };

  task automatic apply_stimulus(input fwd_vec_t v);
    bus.Rs1E      = REG_ADDR_W'(v.rs1e);
    bus.Rs2E      = REG_ADDR_W'(v.rs2e);
    bus.RdM       = REG_ADDR_W'(v.rdm);
    bus.RdW       = REG_ADDR_W'(v.rdw);
    bus.RegWriteM = v.wem;
    bus.RegWriteW = v.wew;
    #2;
    check_output("vec ForwardAE", bus.ForwardAE, v.exp_a);
    check_output("vec ForwardBE", bus.ForwardBE, v.exp_b);
  endtask

  task automatic clear_inputs();
    bus.Dvalid = 0; bus.Mready = 0; bus.Evalid = 0; bus.MultiCycleE = 0;
    bus.Rs1D = 0; bus.Rs2D = 0; bus.Rs1E = 0; bus.Rs2E = 0; bus.RdE = 0;
    bus.MemReadE = 0; bus.RdM = 0; bus.RdW = 0; bus.RegWriteM = 0;
    bus.RegWriteW = 0; bus.PCSrcE = 0;
  endtask

  // Watchdog: the sequence below uses fixed cycle counts, this only guards
  // against the simulation stalling.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset ExBusy", bus.ExBusy, 0);
    check_output("reset stall_cnt", bus.stall_cnt, 0);
    rst = 1'b0;
    next_cycle();

    // Forwarding priority
    bus.RdM = 5; bus.RdW = 5; bus.Rs1E = 5; bus.RegWriteM = 1; bus.RegWriteW = 1;
    #2 check_output("fwd M priority", bus.ForwardAE, 2'b10);
    bus.RegWriteM = 0;
    #2 check_output("fwd W only", bus.ForwardAE, 2'b01);
    bus.Rs1E = 0;
    #2 check_output("fwd x0", bus.ForwardAE, 2'b00);
    next_cycle();
    clear_inputs();
    next_cycle();

    // Load-use
    check_output("lu stall_cnt before", bus.stall_cnt, 0);
    bus.MemReadE = 1; bus.RdE = 7; bus.Rs2D = 7;
    #2;
    check_output("lu StallF", bus.StallF, 1);
    check_output("lu StallD", bus.StallD, 1);
    check_output("lu FlushE", bus.FlushE, 1);
    check_output("lu FlushD", bus.FlushD, 0);
    next_cycle();
    bus.MemReadE = 0;
    #2;
    check_output("lu StallF after", bus.StallF, 0);
    check_output("lu stall_cnt after", bus.stall_cnt, 1);
    bus.MemReadE = 1; bus.RdE = 0; bus.Rs1D = 0; bus.Rs2D = 0;
    #2 check_output("lu rd x0 StallF", bus.StallF, 0);
    next_cycle();
    clear_inputs();
    next_cycle();

    // Multi-cycle op; Evalid in the launch cycle must be ignored
    bus.Dvalid = 1; bus.MultiCycleE = 1; bus.Evalid = 1; bus.Mready = 1;
    #2;
    check_output("mc c0 ExStart", bus.ExStart, 1);
    check_output("mc c0 ExBusy", bus.ExBusy, 0);
    check_output("mc c0 StallF", bus.StallF, 1);
    next_cycle();
    bus.Evalid = 0;
    #2;
    check_output("mc c1 ExStart", bus.ExStart, 0);
    check_output("mc c1 ExBusy", bus.ExBusy, 1);
    repeat (4) next_cycle();
    bus.Evalid = 1;
    next_cycle();
    bus.Dvalid = 0; bus.MultiCycleE = 0; bus.Evalid = 0;
    #2;
    check_output("mc c6 ExBusy", bus.ExBusy, 0);
    check_output("mc stall_cnt", bus.stall_cnt, 7);

    // Backpressure
    next_cycle();
    bus.Dvalid = 1; bus.MultiCycleE = 1; bus.Mready = 0;
    next_cycle();
    bus.Dvalid = 0; bus.MultiCycleE = 0;
    next_cycle();
    next_cycle();
    bus.Evalid = 1;
    next_cycle();
    bus.Evalid = 0;
    #2 check_output("bp c4 ExBusy", bus.ExBusy, 1);
    next_cycle();
    next_cycle();
    bus.Mready = 1;
    #2 check_output("bp c6 ExBusy", bus.ExBusy, 1);
    next_cycle();
    bus.Mready = 0;
    #2;
    check_output("bp c7 ExBusy", bus.ExBusy, 0);
    check_output("bp stall_cnt", bus.stall_cnt, 14);

    // Redirect in IDLE, then ignored while busy
    bus.PCSrcE = 2'b01;
    #2;
    check_output("redir FlushD", bus.FlushD, 1);
    check_output("redir FlushE", bus.FlushE, 1);
    check_output("redir StallF", bus.StallF, 0);
    next_cycle();
    bus.PCSrcE = 0;
    bus.Dvalid = 1; bus.MultiCycleE = 1;
    next_cycle();
    bus.Dvalid = 0; bus.MultiCycleE = 0; bus.PCSrcE = 2'b01;
    #2;
    check_output("busy redir FlushD", bus.FlushD, 0);
    check_output("busy redir FlushE", bus.FlushE, 0);
    bus.PCSrcE = 0;

    // Timeout: 64 BUSY cycles without Evalid (cycles 1..64)
    repeat (63) next_cycle();
    #2 check_output("timeout c64 err", bus.err_timeout, 0);
    next_cycle();
    #2;
    check_output("timeout c65 err", bus.err_timeout, 1);
    check_output("timeout ExBusy", bus.ExBusy, 1);
    repeat (3) next_cycle();
    bus.Evalid = 1; bus.Mready = 1;
    next_cycle();
    bus.Evalid = 0; bus.Mready = 0;
    #2;
    check_output("sticky err", bus.err_timeout, 1);
    check_output("post-timeout ExBusy", bus.ExBusy, 0);

    // Asynchronous reset in the middle of BUSY
    bus.Dvalid = 1; bus.MultiCycleE = 1;
    next_cycle();
    bus.Dvalid = 0; bus.MultiCycleE = 0;
    #2 check_output("pre-reset ExBusy", bus.ExBusy, 1);
    rst = 1'b1;
    #1;
    check_output("async rst ExBusy", bus.ExBusy, 0);
    check_output("async rst err", bus.err_timeout, 0);
    check_output("async rst stall_cnt", bus.stall_cnt, 0);
    check_output("async rst StallF", bus.StallF, 0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Forwarding vectors
    foreach (fwd_vecs[i]) begin
      apply_stimulus(fwd_vecs[i]);
      next_cycle();
    end
    clear_inputs();
    repeat (2) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exu_hazard_sequencer.md
Name: exu_hazard_sequencer

Overview:
- Pipeline-control block for the execute stage. It generates the forwarding selects that drive the EXU operand muxes, and raises load-use stalls and branch/jump/trap flushes.
- It sequences multi-cycle ALU operations (mul/div) through a Dvalid/Evalid/Mready handshake FSM.
- It sits beside the EXU and drives stall/flush into the IF/ID and ID/EX pipeline registers.
- It also keeps a stall-cycle performance counter and a busy-timeout error flag.

Parameters:
- REG_ADDR_W, 5, register-index width
- PERF_W, 32, stall performance counter width
- BUSY_TIMEOUT, 64, maximum BUSY cycles before err_timeout sets (must be ≥2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- Dvalid  in  1  ID/EX holds a valid instruction
- Mready  in  1  memory stage can accept a result
- Evalid  in  1  ALU result valid (multi-cycle completion)
- MultiCycleE  in  1  instruction in E is a multi-cycle ALU op
- Rs1D, Rs2D  in  REG_ADDR_W  source regs in decode
- Rs1E, Rs2E, RdE  in  REG_ADDR_W  source/dest regs in execute
- MemReadE  in  1  instruction in E is a load
- RdM, RdW  in  REG_ADDR_W  dest regs in M / W
- RegWriteM, RegWriteW  in  1  register-write enables in M / W
- PCSrcE  in  2  PC source from E; non-zero means redirect
- ForwardAE, ForwardBE  out  2  00=RD, 01=ResultW, 10=ALUResultM
- StallF, StallD  out  1  hold PC / IF-ID register
- FlushD, FlushE  out  1  clear IF-ID / ID-EX register
- ExStart  out  1  one-cycle start pulse to multi-cycle ALU
- ExBusy  out  1  FSM not IDLE
- err_timeout  out  1  sticky: BUSY exceeded BUSY_TIMEOUT
- stall_cnt  out  PERF_W  cycles with StallF asserted

Behaviour:
- Reset (async, rst=1): FSM→IDLE; busy counter=0; stall_cnt=0; err_timeout=0. All outputs are 0 while rst is high.
- Forwarding (combinational, evaluated for A and B independently):
  - 10 if RegWriteM && RdM!=0 && RdM==RsxE.
  - Else 01 if RegWriteW && RdW!=0 && RdW==RsxE.
  - Else 00.
  - M has priority over W. x0 is never forwarded.
- Load-use: lu = MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- FSM states:
  - IDLE: if Dvalid && MultiCycleE, pulse ExStart for 1 cycle and go to BUSY (counter cleared). Otherwise stay in IDLE.
  - BUSY: counter increments each cycle, saturating at BUSY_TIMEOUT. If Evalid && Mready → IDLE. If Evalid && !Mready → HOLD. If the counter reaches BUSY_TIMEOUT with no Evalid, set err_timeout and remain in BUSY.
  - HOLD: wait for Mready, then → IDLE.
  - ExStart is never asserted outside the IDLE→BUSY transition. ExBusy=1 in BUSY and in HOLD.
- Stall and flush:
  - StallF = StallD = lu || ExBusy || (IDLE && Dvalid && MultiCycleE).
  - FlushE = lu || (redirect && !ExBusy), where redirect = PCSrcE!=0.
  - FlushD = redirect && !ExBusy.
  - Redirect is ignored while ExBusy. Only non-multi-cycle instructions can redirect.
  - When lu and redirect occur together, both flushes assert and the stall still holds F/D. The redirect wins next cycle via the PC mux.
- stall_cnt: +1 on each cycle with StallF=1; wraps modulo 2^PERF_W.
- Simultaneous events: if Evalid arrives in the same cycle BUSY is entered, it is ignored. Evalid is sampled only in BUSY.
- Reset mid-operation: immediately returns to IDLE and drops ExBusy/ExStart. No result is delivered.

Test Plan:
1. Forwarding priority: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 → ForwardAE=10. With RegWriteM=0 → ForwardAE=01. With Rs1E=0 → ForwardAE=00.
2. Load-use: MemReadE=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for exactly that cycle, and stall_cnt increments by 1. With RdE=0 → no stall.
3. Multi-cycle op:
   - Dvalid=1, MultiCycleE=1 at cycle 0 → ExStart=1 only at cycle 0.
   - ExBusy=1 from cycle 1. Evalid=1, Mready=1 at cycle 5 → IDLE at cycle 6.
   - StallF high cycles 0–5, so stall_cnt=6.
4. Backpressure: Evalid at cycle 3 with Mready=0 → HOLD. Mready=1 at cycle 6 → IDLE at cycle 7, and ExBusy stays 1 through cycle 6.
5. Redirect: PCSrcE=01 in IDLE → FlushD=FlushE=1. The same PCSrcE while ExBusy=1 → no flush.
6. Timeout/reset: BUSY with no Evalid for 64 cycles → err_timeout=1 (sticky). Asserting rst mid-BUSY → ExBusy=0 and err_timeout=0 asynchronously, and stall_cnt=0.
